oh_enc_pipe: RTL and testbench
==============================

Name: oh_enc_pipe

Overview:
- Registered, handshaked successor to the combinational one-hot-to-binary converter.
- Takes a W-bit request vector and emits:
  - a binary index;
  - a cleaned one-hot vector;
  - status flags.
- Supports three encoding modes: strict one-hot, fixed low-priority, and round-robin with persistent pointer state.
- Sits between request sources (interrupt lines, arbiter requests, cache-way hit vectors) and consumers needing an index, with valid/ready flow control on both sides.

Parameters:
- W, 8, width of input vector; legal W>=2.
- MODE, 0, 0=STRICT (OR-of-bits encode, W-bit pass-through), 1=PRIO (lowest set bit wins), 2=RR (round-robin, lowest set bit at or above pointer wins).
- IW, $clog2(W), index width (derived; not to be overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input this cycle.
- in_vec  in  W  request vector.
- out_valid  out  1  output registers hold a result.
- out_ready  in  1  consumer accepts result.
- out_idx  out  IW  encoded index.
- out_oh  out  W  one-hot of winning bit (all zero if none).
- out_zero  out  1  input vector was all zero.
- out_multi  out  1  input vector had more than one bit set.

Behaviour:
- Clock and reset: one clock (clk); rst synchronous, active-high.
- Reset values: out_valid=0, out_idx=0, out_oh=0, out_zero=0, out_multi=0, RR pointer=0; in_ready=1 the cycle after reset.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Full throughput: one transfer per cycle.
- Latency:
  - Exactly one cycle from input transfer to out_valid=1 with the result.
  - Output fields stable while out_valid&&!out_ready.
- Zero input: out_zero=1, out_idx=0, out_oh=0, out_multi=0. Transfers normally; never dropped.
- STRICT mode:
  - out_idx[b] = OR over i of (in_vec[i] && bit b of i).
  - out_oh = in_vec.
  - out_multi flags a malformed vector; the index is the OR-merge and is documented as garbage in that case.
- PRIO mode:
  - Winner = lowest set bit.
  - out_oh = winner only.
  - out_multi still reported.
- RR mode:
  - Winner = lowest set bit with index >= ptr.
  - If there is none, winner = lowest set bit overall (wrap-around).
  - On input transfer with a nonzero vector: ptr <= winner+1, wrapping to 0 when winner = W-1.
  - Zero vectors leave ptr unchanged.
  - ptr is W-bit thermometer or IW-bit binary (implementer's choice); it must be invisible at ports.
- Simultaneous output drain and new input: the output register is replaced in the same edge and out_valid stays 1.
- Reset mid-operation: the held result is discarded and ptr returns to 0.
- Non-power-of-two W: indices >= W never produced.

Optional Feature:
- Macro: OH_ENC_PIPE_ERRCNT_EN.
- When defined:
  - Extra port err_cnt out 16, a saturating count of accepted input vectors with out_multi condition.
  - Counter resets to 0 on rst and holds at 16'hFFFF.
  - Counted on input transfer.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package oh_enc_pkg:
  - MODE constants OH_ENC_STRICT=0, OH_ENC_PRIO=1, OH_ENC_RR=2;
  - function to compute the multi-hot flag (popcount>1 via x&(x-1)!=0).
- Sub-module oh_prio_find (combinational; param W):
  - inputs vec[W], outputs found, idx[IW], oh[W] for lowest set bit.
  - Instantiated twice in RR (masked by ptr and unmasked) and once in PRIO.

Test Plan:
- STRICT, W=8, in_vec=8'b0010_0000, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_oh=8'h20, out_zero=0, out_multi=0.
- PRIO, W=8, in_vec=8'b1010_1000 -> out_idx=3, out_oh=8'h08, out_multi=1; in_vec=0 -> out_zero=1, out_idx=0, out_oh=0.
- RR, W=4, in_vec=4'b1111 held for 5 transfers -> out_idx sequence 0,1,2,3,0; then in_vec=4'b0011 after winner 3 -> idx 0, then 1.
- Backpressure, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out fields stable; out_ready=1 -> one result drained and next accepted in the same cycle, no loss or duplication (scoreboard 100 random vectors).
- Reset mid-stream, RR with ptr=2 and out_valid=1, assert rst one cycle -> out_valid=0, and next in_vec=4'b1111 yields idx 0.
- OH_ENC_PIPE_ERRCNT_EN defined: 3 multi-hot accepted plus 2 single-hot -> err_cnt=3; force 70000 multi-hot -> err_cnt=16'hFFFF.

Source files
------------

// File: rtl/oh_enc_pkg.sv
// Shared constants and helpers for the pipelined one-hot encoder.
package oh_enc_pkg;

  localparam int OH_ENC_STRICT = 0;
  localparam int OH_ENC_PRIO   = 1;
  localparam int OH_ENC_RR     = 2;

  // Vectors up to 64 bits wide; narrower callers zero-extend.
  function automatic logic is_multi_hot(input logic [63:0] x);
    return (x & (x - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/oh_prio_find.sv
// Combinational lowest-set-bit finder: presence flag, binary index and isolated one-hot.
module oh_prio_find #(
  parameter  int W  = 8,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [W-1:0]  oh
);

  assign found = |vec;
  assign oh    = vec & (~vec + W'(1));

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/oh_enc_pipe.sv
// Registered one-hot encoder (STRICT / PRIO / RR) with valid/ready on both sides.
// Defining OH_ENC_PIPE_ERRCNT_EN adds err_cnt, a saturating count of accepted multi-hot inputs.
module oh_enc_pipe
  import oh_enc_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int MODE = OH_ENC_STRICT,
  localparam int IW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [W-1:0]  out_oh,
  output logic          out_zero,
  output logic          out_multi
`ifdef OH_ENC_PIPE_ERRCNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  logic          accept;
  logic          vec_zero;
  logic          vec_multi;
  logic [IW-1:0] res_idx;
  logic [W-1:0]  res_oh;

  logic          out_valid_q;
  logic [IW-1:0] out_idx_q;
  logic [W-1:0]  out_oh_q;
  logic          out_zero_q;
  logic          out_multi_q;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign vec_zero  = (in_vec == '0);
  assign vec_multi = is_multi_hot(64'(in_vec));

  generate
    if (MODE == OH_ENC_PRIO) begin : g_prio
      logic          p_found;
      logic [IW-1:0] p_idx;
      logic [W-1:0]  p_oh;

      oh_prio_find #(.W(W)) u_find (.vec(in_vec), .found(p_found), .idx(p_idx), .oh(p_oh));

      assign res_idx = p_idx;
      assign res_oh  = p_found ? p_oh : '0;

    end else if (MODE == OH_ENC_RR) begin : g_rr
      logic [IW-1:0] ptr_q, ptr_d;
      logic [W-1:0]  masked_vec;
      logic          hi_found, lo_found;
      logic [IW-1:0] hi_idx, lo_idx;
      logic [W-1:0]  hi_oh, lo_oh;

      always_comb begin
        masked_vec = '0;
        for (int i = 0; i < W; i++) masked_vec[i] = in_vec[i] && (IW'(i) >= ptr_q);
      end

      oh_prio_find #(.W(W)) u_find_hi (.vec(masked_vec), .found(hi_found), .idx(hi_idx), .oh(hi_oh));
      oh_prio_find #(.W(W)) u_find_lo (.vec(in_vec),     .found(lo_found), .idx(lo_idx), .oh(lo_oh));

      // Nothing at or above the pointer: wrap to the lowest request overall.
      assign res_idx = hi_found ? hi_idx : lo_idx;
      assign res_oh  = hi_found ? hi_oh : (lo_found ? lo_oh : '0);

      always_comb begin
        ptr_d = ptr_q;
        if (accept && !vec_zero) ptr_d = (res_idx == IW'(W - 1)) ? '0 : res_idx + IW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
      end

    end else begin : g_strict
      // NOTE: every always_comb output gets a default before any conditional update,
      // otherwise the tool infers a latch to hold the old value.
      always_comb begin
        res_idx = '0;
        for (int i = 0; i < W; i++) begin
          if (in_vec[i]) res_idx = res_idx | IW'(i);
        end
      end

      assign res_oh = in_vec;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_oh_q    <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_idx_q   <= res_idx;
      out_oh_q    <= res_oh;
      out_zero_q  <= vec_zero;
      out_multi_q <= vec_multi;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_oh    = out_oh_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;

`ifdef OH_ENC_PIPE_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && vec_multi && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_oh_enc_pipe.sv
// Directed bench for oh_enc_pipe: STRICT and PRIO at W=8, RR at W=4, sharing one clock and reset.
module tb_oh_enc_pipe;
  import oh_enc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv_s, iv_p, iv_r;
  logic       ordy_s, ordy_p, ordy_r;
  logic [7:0] vec_s, vec_p;
  logic [3:0] vec_r;
  logic       irdy_s, irdy_p, irdy_r;
  logic       ov_s, ov_p, ov_r;
  logic [2:0] idx_s, idx_p;
  logic [1:0] idx_r;
  logic [7:0] oh_s, oh_p;
  logic [3:0] oh_r;
  logic       z_s, z_p, z_r;
  logic       m_s, m_p, m_r;
`ifdef OH_ENC_PIPE_ERRCNT_EN
  logic [15:0] ec_s, ec_p, ec_r;
`endif

  oh_enc_pipe #(.W(8), .MODE(OH_ENC_STRICT)) u_strict (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(irdy_s), .in_vec(vec_s),
    .out_valid(ov_s), .out_ready(ordy_s), .out_idx(idx_s), .out_oh(oh_s),
    .out_zero(z_s), .out_multi(m_s)
`ifdef OH_ENC_PIPE_ERRCNT_EN
    , .err_cnt(ec_s)
`endif
  );

  oh_enc_pipe #(.W(8), .MODE(OH_ENC_PRIO)) u_prio (
    .clk(clk), .rst(rst), .in_valid(iv_p), .in_ready(irdy_p), .in_vec(vec_p),
    .out_valid(ov_p), .out_ready(ordy_p), .out_idx(idx_p), .out_oh(oh_p),
    .out_zero(z_p), .out_multi(m_p)
`ifdef OH_ENC_PIPE_ERRCNT_EN
    , .err_cnt(ec_p)
`endif
  );

  oh_enc_pipe #(.W(4), .MODE(OH_ENC_RR)) u_rr (
    .clk(clk), .rst(rst), .in_valid(iv_r), .in_ready(irdy_r), .in_vec(vec_r),
    .out_valid(ov_r), .out_ready(ordy_r), .out_idx(idx_r), .out_oh(oh_r),
    .out_zero(z_r), .out_multi(m_r)
`ifdef OH_ENC_PIPE_ERRCNT_EN
    , .err_cnt(ec_r)
`endif
  );

  // Observation mux so the vector loop can compare any instance the same way.
  int         sel;
  logic       obs_ready, obs_valid, obs_zero, obs_multi;
  logic [2:0] obs_idx;
  logic [7:0] obs_oh;

  always_comb begin
    case (sel)
      0: begin
        obs_ready = irdy_s; obs_valid = ov_s; obs_idx = idx_s; obs_oh = oh_s;
        obs_zero  = z_s;    obs_multi = m_s;
      end
      1: begin
        obs_ready = irdy_p; obs_valid = ov_p; obs_idx = idx_p; obs_oh = oh_p;
        obs_zero  = z_p;    obs_multi = m_p;
      end
      default: begin
        obs_ready = irdy_r; obs_valid = ov_r; obs_idx = {1'b0, idx_r}; obs_oh = {4'b0, oh_r};
        obs_zero  = z_r;    obs_multi = m_r;
      end
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Single-cycle transfer on the selected instance; returns 1 time unit after the edge.
  task automatic xfer(input int s, input logic [7:0] v);
    case (s)
      0:       begin iv_s = 1'b1; vec_s = v; end
      1:       begin iv_p = 1'b1; vec_p = v; end
      default: begin iv_r = 1'b1; vec_r = v[3:0]; end
    endcase
    @(posedge clk);
    #1;
    iv_s = 1'b0; iv_p = 1'b0; iv_r = 1'b0;
  endtask

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  typedef struct {
    int         sel;
    logic [7:0] vec;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       zero;
    logic       multi;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // STRICT, W=8: OR-merged index, pass-through one-hot.
    tbl.push_back('{0, 8'h20, 3'd5, 8'h20, 1'b0, 1'b0});
    tbl.push_back('{0, 8'h01, 3'd0, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{0, 8'h80, 3'd7, 8'h80, 1'b0, 1'b0});
    tbl.push_back('{0, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{0, 8'h0A, 3'd3, 8'h0A, 1'b0, 1'b1});
    tbl.push_back('{0, 8'h90, 3'd7, 8'h90, 1'b0, 1'b1});
    // PRIO, W=8: lowest set bit.
    tbl.push_back('{1, 8'hA8, 3'd3, 8'h08, 1'b0, 1'b1});
    tbl.push_back('{1, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1, 8'h80, 3'd7, 8'h80, 1'b0, 1'b0});
    tbl.push_back('{1, 8'hFF, 3'd0, 8'h01, 1'b0, 1'b1});
    tbl.push_back('{1, 8'h06, 3'd1, 8'h02, 1'b0, 1'b1});
    tbl.push_back('{1, 8'h40, 3'd6, 8'h40, 1'b0, 1'b0});
    // RR, W=4, ptr from reset 0: two full rotations, then wrap, zero and pointer cases.
    for (int r = 0; r < 8; r++)
      tbl.push_back('{2, 8'h0F, 3'(r % 4), 8'(1 << (r % 4)), 1'b0, 1'b1});
    tbl.push_back('{2, 8'h03, 3'd0, 8'h01, 1'b0, 1'b1}); // ptr 0 -> 1
    tbl.push_back('{2, 8'h03, 3'd1, 8'h02, 1'b0, 1'b1}); // ptr 1 -> 2
    tbl.push_back('{2, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0}); // ptr stays 2
    tbl.push_back('{2, 8'h03, 3'd0, 8'h01, 1'b0, 1'b1}); // wrap, ptr -> 1
    tbl.push_back('{2, 8'h08, 3'd3, 8'h08, 1'b0, 1'b0}); // ptr -> 0
    tbl.push_back('{2, 8'h0C, 3'd2, 8'h04, 1'b0, 1'b1}); // ptr -> 3
    tbl.push_back('{2, 8'h05, 3'd0, 8'h01, 1'b0, 1'b1}); // wrap, ptr -> 1

    iv_s = 1'b0; iv_p = 1'b0; iv_r = 1'b0;
    vec_s = '0; vec_p = '0; vec_r = '0;
    ordy_s = 1'b0; ordy_p = 1'b0; ordy_r = 1'b0;
    sel = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with out_ready low so in_ready must come from !out_valid.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset_valid[%0d]", s), obs_valid, 0);
      check($sformatf("reset_ready[%0d]", s), obs_ready, 1);
      check($sformatf("reset_idx[%0d]", s),   obs_idx, 0);
      check($sformatf("reset_oh[%0d]", s),    obs_oh, 0);
      check($sformatf("reset_zero[%0d]", s),  obs_zero, 0);
      check($sformatf("reset_multi[%0d]", s), obs_multi, 0);
    end
    ordy_s = 1'b1; ordy_p = 1'b1; ordy_r = 1'b1;

    foreach (tbl[k]) begin
      sel = tbl[k].sel;
      #1;
      check($sformatf("v%0d_in_ready", k), obs_ready, 1);
      xfer(tbl[k].sel, tbl[k].vec);
      check($sformatf("v%0d_valid", k), obs_valid, 1);
      check($sformatf("v%0d_idx", k),   obs_idx, tbl[k].idx);
      check($sformatf("v%0d_oh", k),    obs_oh, tbl[k].oh);
      check($sformatf("v%0d_zero", k),  obs_zero, tbl[k].zero);
      check($sformatf("v%0d_multi", k), obs_multi, tbl[k].multi);
    end

    // Backpressure on PRIO: result A held for 3 cycles while B waits.
    ordy_p = 1'b0;
    xfer(1, 8'h30);
    iv_p = 1'b1; vec_p = 8'h04;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_in_ready", c), irdy_p, 0);
      check($sformatf("bp%0d_valid", c),    ov_p, 1);
      check($sformatf("bp%0d_idx", c),      idx_p, 4);
      check($sformatf("bp%0d_oh", c),       oh_p, 8'h10);
      check($sformatf("bp%0d_multi", c),    m_p, 1);
      @(posedge clk);
      #1;
    end
    ordy_p = 1'b1;
    #1;
    check("bp_release_in_ready", irdy_p, 1);
    @(posedge clk);
    #1;
    iv_p = 1'b0;
    check("bp_next_valid", ov_p, 1);
    check("bp_next_idx",   idx_p, 2);
    check("bp_next_oh",    oh_p, 8'h04);
    check("bp_next_multi", m_p, 0);
    @(posedge clk);
    #1;
    check("bp_drained", ov_p, 0);

    // Random traffic through PRIO against a FIFO scoreboard.
    begin
      logic [7:0] q_vec[$];
      logic [7:0] e;
      int accepted = 0;
      int drained  = 0;
      int cyc      = 0;
      while ((accepted < 100 || q_vec.size() > 0) && cyc < 3000) begin
        if (accepted < 100) begin
          iv_p  = ($urandom_range(0, 3) != 0);
          vec_p = 8'($urandom);
        end else begin
          iv_p = 1'b0;
        end
        ordy_p = ($urandom_range(0, 3) != 0);
        #1;
        if (ov_p && ordy_p) begin
          if (q_vec.size() == 0) begin
            check("sb_unexpected_output", 1, 0);
          end else begin
            e = q_vec.pop_front();
            check($sformatf("sb%0d_idx", drained),  idx_p, low_idx(e));
            check($sformatf("sb%0d_oh", drained),   oh_p, e & (~e + 8'd1));
            check($sformatf("sb%0d_zero", drained), z_p, (e == 8'h00));
            drained++;
          end
        end
        if (iv_p && irdy_p) begin
          q_vec.push_back(vec_p);
          accepted++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      iv_p = 1'b0; ordy_p = 1'b1;
      check("sb_cycle_budget", (cyc < 3000), 1);
      check("sb_drained_count", drained, 100);
    end

    // Reset mid-stream on RR with ptr=2 and a held result.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sel = 2;
    xfer(2, 8'h0F);
    check("rr_pre0_idx", idx_r, 0);
    xfer(2, 8'h0F);
    check("rr_pre1_idx", idx_r, 1);
    check("rr_pre1_valid", ov_r, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rr_rst_valid", ov_r, 0);
    check("rr_rst_idx",   idx_r, 0);
    check("rr_rst_ready", irdy_r, 1);
    xfer(2, 8'h0F);
    check("rr_post_idx", idx_r, 0);
    check("rr_post_oh",  oh_r, 4'h1);

`ifdef OH_ENC_PIPE_ERRCNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("errcnt_reset", ec_p, 0);
    xfer(1, 8'h03);
    xfer(1, 8'h81);
    xfer(1, 8'hFF);
    xfer(1, 8'h01);
    xfer(1, 8'h40);
    check("errcnt_three", ec_p, 3);
    iv_p = 1'b1; vec_p = 8'hFF;
    repeat (70000) @(posedge clk);
    #1;
    iv_p = 1'b0;
    check("errcnt_saturated", ec_p, 16'hFFFF);
    xfer(1, 8'h11);
    check("errcnt_holds", ec_p, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
